z_frame_collect: RTL and testbench
==================================

# z_frame_collect

Upstream stage that assembles a serial stream of `z_ing` words into the parallel `struct_z_l[8:0]` frame array and `struct_z` word consumed by the packed-struct stage downstream. Beats arrive on a `data_inf_c` slave port; each frame is delimited by `last`. The completed frame is held stable behind a valid/ready handshake until the downstream stage takes it.

## Interface
- `DEPTH`, 9: frame array entries; must match the downstream `struct_z_l` size.
- `LEN_W`, 10: width of `frame_len`.
- `clock`  in  1: single clock; all logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `s_inf`  `data_inf_c.slaver`  `DSIZE=$bits(z_ing)`: input stream with `data`, `valid`, `ready`, `last`.
- `struct_z_l`  out  `z_ing [DEPTH-1:0]`: assembled frame; beat k lands in entry k.
- `struct_z`  out  `z_ing`: last word stored in the array.
- `frame_vld`  out  1: frame complete and stable.
- `frame_rdy`  in  1: downstream accepts the frame.
- `frame_len`  out  `LEN_W`: beats received in the frame, including dropped beats; saturates at 1023.
- `ovf`  out  1: frame exceeded `DEPTH` beats.
- `short`  out  1: frame ended before `DEPTH` beats.

## Operation
- States are `FILL`, `DRAIN` and `HOLD`. Reset state is `FILL`.
- Accept = `s_inf.valid && s_inf.ready`.
- `s_inf.ready` = 1 in `FILL` and `DRAIN`, and 0 in `HOLD`.
- In `FILL`, an accepted beat writes `data` into `struct_z_l[wptr]` and `struct_z`, then increments `wptr`.
- `FILL`→`HOLD`: an accepted beat has `last`=1 (any `wptr` ≤ `DEPTH-1`).
- `FILL`→`DRAIN`: an accepted beat has `wptr==DEPTH-1` and `last`=0.
- In `DRAIN`, accepted beats are discarded: the array and `struct_z` are unchanged, and only `frame_len` counts.
- `DRAIN`→`HOLD`: an accepted beat has `last`=1.
- `HOLD`→`FILL`: `frame_vld && frame_rdy`.
  - On that transition, the array, `struct_z`, `wptr`, `frame_len`, `ovf` and `short` all clear to 0.
  - Unfilled entries of a short frame therefore read 0.
- `ovf` sets on the `FILL`→`DRAIN` transition.
- `short` sets on a `FILL`→`HOLD` transition with `wptr<DEPTH-1`.
- `frame_len` increments on every accept and holds at 1023 once saturated; `wptr` never wraps.
- Reset mid-frame or in `HOLD`: all outputs return to reset values the next cycle and the partial frame is lost. `s_inf.ready` is 1 the cycle after `rst` deasserts.
- Reset values: `struct_z_l`=0, `struct_z`=0, `frame_vld`=0, `frame_len`=0, `ovf`=0, `short`=0, state=`FILL`. `s_inf.ready` is 1 while in `FILL`, including during reset.

## Timing
- All outputs are registered; the only combinational output is `s_inf.ready`, decoded from the state.
- A beat accepted at edge n is visible on `struct_z_l`/`struct_z` after edge n.
- `frame_vld` is 1 exactly while in `HOLD`, i.e. from the edge of the terminating accept until the edge of the frame handshake.
- Simultaneous events are impossible: no beat is accepted in the cycle that `frame_rdy` completes the handshake, because `s_inf.ready`=0 in `HOLD`.
- Earliest new-frame accept: one cycle after the handshake.
- Throughput: one beat per cycle; one bubble cycle per frame minimum.
- `frame_rdy` may be held high continuously; the frame is then held for exactly one cycle.
- While `frame_vld`=1, outputs are stable regardless of `s_inf` activity.

## Structure
- `z_ing` stays in `test_package`: packed struct, field `op[3:0]`.
- Add to `test_package`: `typedef enum logic [1:0] {FILL, DRAIN, HOLD} zfc_state_e;` and `localparam int ZFC_DEPTH = 9;`.
- Import the package in the module header.
- Single module. No sub-module is warranted: the array write is a decoded register bank indexed by `wptr` (`$clog2(DEPTH)` bits).

## Test plan
- Nine beats with `op`=1..9, `last` on beat 9, `frame_rdy`=0 → `frame_vld`=1 the cycle after beat 9, entries 0..8 = 1..9, `struct_z.op`=9, `frame_len`=9, `ovf`=0, `short`=0, `s_inf.ready`=0; assert `frame_rdy` → `frame_vld`=0 and array=0 next cycle.
- Three beats `op`=A,B,C with `last` on beat 3 → entries 0..2 = A,B,C, entries 3..8 = 0, `short`=1, `frame_len`=3.
- Twelve beats with `last` on beat 12 → entries hold beats 1..9, `struct_z` = beat 9, `ovf`=1, `frame_len`=12, `frame_vld` after beat 12.
- Single beat with `last`=1 → `short`=1, `frame_len`=1, entry 0 set; back-to-back frames with `frame_rdy` tied 1 → one bubble cycle between frames, no beat lost.
- Assert `rst` after four beats of a frame → next cycle all outputs 0, `s_inf.ready`=1; a following complete frame assembles correctly.
- Random `valid` gaps and `frame_rdy` stalls over 200 frames → scoreboard match, and `s_inf.ready`=0 whenever `frame_vld`=1.

Source files
------------

// File: rtl/z_frame_collect_pkg.sv
// Shared types for the z_ing frame path: the beat word, the collector FSM
// states and the frame depth agreed with the downstream packed-struct stage.
package test_package;

  typedef struct packed {
    logic [3:0] op;
  } z_ing;

  typedef enum logic [1:0] {FILL, DRAIN, HOLD} zfc_state_e;

  localparam int ZFC_DEPTH = 9;

endpackage

// File: rtl/data_inf_c.sv
// Streaming beat interface: data/last qualified by valid, flow-controlled by ready.
// A beat transfers on a rising edge where valid && ready; the sender holds
// data/last stable while valid is high and ready is low.
interface data_inf_c #(
  parameter int DSIZE = 8
) ();

  logic [DSIZE-1:0] data;
  logic             valid;
  logic             ready;
  logic             last;

  modport master (output data, output valid, output last, input ready);
  modport slaver (input data, input valid, input last, output ready);

endinterface

// File: rtl/z_frame_collect.sv
// Collects a last-delimited stream of z_ing beats into a DEPTH-entry frame
// array and presents it behind a frame_vld/frame_rdy handshake.
module z_frame_collect
  import test_package::*;
#(
  parameter int DEPTH = ZFC_DEPTH,
  parameter int LEN_W = 10
) (
  input  logic                 clock,
  input  logic                 rst,
  data_inf_c.slaver            s_inf,
  output z_ing [DEPTH-1:0]     struct_z_l,
  output z_ing                 struct_z,
  output logic                 frame_vld,
  input  logic                 frame_rdy,
  output logic [LEN_W-1:0]     frame_len,
  output logic                 ovf,
  output logic                 short,
  output zfc_state_e           state_dbg
);

  localparam int               PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [LEN_W-1:0] LEN_MAX  = '1;

  zfc_state_e       state;
  zfc_state_e       state_next;
  logic [PTR_W-1:0] wptr;
  logic             accept;
  logic             fill_to_drain;
  logic             fill_to_hold;
  logic             release_frame;
  z_ing             din;

  // ready is a pure state decode, so the frame cannot change while it is held.
  assign s_inf.ready = (state != HOLD);
  assign accept      = s_inf.valid && s_inf.ready;
  assign din         = z_ing'(s_inf.data);
  assign state_dbg   = state;

  always_comb begin
    state_next    = state;
    fill_to_drain = 1'b0;
    fill_to_hold  = 1'b0;
    release_frame = 1'b0;
    case (state)
      FILL: begin
        if (accept && s_inf.last) begin
          fill_to_hold = 1'b1;
          state_next   = HOLD;
        end else if (accept && (wptr == LAST_PTR)) begin
          fill_to_drain = 1'b1;
          state_next    = DRAIN;
        end
      end
      DRAIN: begin
        if (accept && s_inf.last) state_next = HOLD;
      end
      HOLD: begin
        if (frame_vld && frame_rdy) begin
          release_frame = 1'b1;
          state_next    = FILL;
        end
      end
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state      <= FILL;
      frame_vld  <= 1'b0;
      wptr       <= '0;
      struct_z_l <= '0;
      struct_z   <= '0;
      frame_len  <= '0;
      ovf        <= 1'b0;
      short      <= 1'b0;
    end else begin
      state     <= state_next;
      frame_vld <= (state_next == HOLD);
      if (release_frame) begin
        wptr       <= '0;
        struct_z_l <= '0;
        struct_z   <= '0;
        frame_len  <= '0;
        ovf        <= 1'b0;
        short      <= 1'b0;
      end else begin
        if (accept && (frame_len != LEN_MAX)) frame_len <= frame_len + 1'b1;
        // Beats past the array end only extend frame_len; wptr parks on the last entry.
        if (accept && (state == FILL)) begin
          struct_z_l[wptr] <= din;
          struct_z         <= din;
          if (wptr != LAST_PTR) wptr <= wptr + 1'b1;
        end
        if (fill_to_drain) ovf <= 1'b1;
        if (fill_to_hold && (wptr != LAST_PTR)) short <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_z_frame_collect.sv
// Directed and randomized checks of z_frame_collect frame assembly and handshake.
module tb_z_frame_collect;
  import test_package::*;

  localparam int DEPTH = 9;
  localparam int LEN_W = 10;
  localparam int AW    = DEPTH * 4;
  localparam int EW    = AW + LEN_W + 2;
  localparam int N_RND = 200;

  logic              clock = 1'b0;
  logic              rst;
  logic              frame_rdy;
  z_ing [DEPTH-1:0]  struct_z_l;
  z_ing              struct_z;
  logic              frame_vld;
  logic [LEN_W-1:0]  frame_len;
  logic              ovf;
  logic              short;
  zfc_state_e        state_dbg;
  logic [AW-1:0]     arr_flat;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc_cyc = 0;

  logic [EW-1:0] exp_q[$];

  data_inf_c #(.DSIZE($bits(z_ing))) s_inf ();

  z_frame_collect #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clock      (clock),
    .rst        (rst),
    .s_inf      (s_inf),
    .struct_z_l (struct_z_l),
    .struct_z   (struct_z),
    .frame_vld  (frame_vld),
    .frame_rdy  (frame_rdy),
    .frame_len  (frame_len),
    .ovf        (ovf),
    .short      (short),
    .state_dbg  (state_dbg)
  );

  assign arr_flat = struct_z_l;

  // clock / reset
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic send_beat(input logic [3:0] op, input logic last);
    int   tries;
    logic acc;
    tries = 0;
    s_inf.valid = 1'b1;
    s_inf.data  = op;
    s_inf.last  = last;
    do begin
      acc = s_inf.ready;
      @(posedge clock);
      #1;
      tries++;
    end while (!acc && tries < 64);
    if (!acc) begin
      checks++; errors++;
      $display("FAIL send_beat_timeout: ready=0 for %0d cycles, required 1", tries);
    end
    last_acc_cyc = cyc;
  endtask

  task automatic idle(input int n);
    s_inf.valid = 1'b0;
    s_inf.last  = 1'b0;
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic release_frame();
    s_inf.valid = 1'b0;
    frame_rdy   = 1'b1;
    @(posedge clock);
    #1;
    frame_rdy = 1'b0;
    checks++;
    if (frame_vld !== 1'b0 || arr_flat !== '0 || frame_len !== '0) begin
      errors++;
      $display("FAIL release: vld=%b arr=%h len=%0d, required 0/0/0", frame_vld, arr_flat, frame_len);
    end
  endtask

  // scenarios
  task automatic test_reset();
    rst = 1'b1; frame_rdy = 1'b0;
    s_inf.valid = 1'b0; s_inf.last = 1'b0; s_inf.data = '0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if (s_inf.ready !== 1'b1) begin errors++; $display("FAIL reset_ready_in_rst: got %b required 1", s_inf.ready); end
    checks++;
    if (frame_vld !== 1'b0 || ovf !== 1'b0 || short !== 1'b0 || frame_len !== '0) begin
      errors++;
      $display("FAIL reset_flags: vld=%b ovf=%b short=%b len=%0d required all 0", frame_vld, ovf, short, frame_len);
    end
    checks++;
    if (arr_flat !== '0 || struct_z !== '0) begin
      errors++; $display("FAIL reset_data: arr=%h z=%h required 0", arr_flat, struct_z);
    end
    checks++;
    if (state_dbg !== FILL) begin errors++; $display("FAIL reset_state: got %0d required FILL", state_dbg); end
    rst = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if (s_inf.ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b required 1", s_inf.ready); end
  endtask

  task automatic test_full_frame();
    logic [AW-1:0] exp_arr;
    exp_arr = '0;
    for (int k = 1; k <= 9; k++) begin
      exp_arr[(k-1)*4 +: 4] = 4'(k);
      send_beat(4'(k), k == 9);
    end
    s_inf.valid = 1'b0;
    checks++;
    if (frame_vld !== 1'b1 || s_inf.ready !== 1'b0) begin
      errors++; $display("FAIL full_vld: vld=%b ready=%b required 1/0", frame_vld, s_inf.ready);
    end
    checks++;
    if (arr_flat !== exp_arr || struct_z.op !== 4'd9) begin
      errors++; $display("FAIL full_data: arr=%h z=%h required %h/9", arr_flat, struct_z, exp_arr);
    end
    checks++;
    if (frame_len !== 10'd9 || ovf !== 1'b0 || short !== 1'b0) begin
      errors++; $display("FAIL full_flags: len=%0d ovf=%b short=%b required 9/0/0", frame_len, ovf, short);
    end
    // upstream keeps presenting a beat while the frame is held
    s_inf.valid = 1'b1; s_inf.data = 4'hf; s_inf.last = 1'b1;
    @(posedge clock);
    #1;
    s_inf.valid = 1'b0;
    checks++;
    if (frame_vld !== 1'b1 || arr_flat !== exp_arr || struct_z.op !== 4'd9 || frame_len !== 10'd9) begin
      errors++;
      $display("FAIL full_stable: vld=%b arr=%h z=%h len=%0d required 1/%h/9/9", frame_vld, arr_flat, struct_z, frame_len, exp_arr);
    end
    release_frame();
    checks++;
    if (s_inf.ready !== 1'b1 || struct_z !== '0) begin
      errors++; $display("FAIL full_after: ready=%b z=%h required 1/0", s_inf.ready, struct_z);
    end
  endtask

  task automatic test_short();
    send_beat(4'ha, 1'b0);
    send_beat(4'hb, 1'b0);
    send_beat(4'hc, 1'b1);
    s_inf.valid = 1'b0;
    checks++;
    if (arr_flat !== 36'h000000cba || struct_z.op !== 4'hc) begin
      errors++; $display("FAIL short_data: arr=%h z=%h required 000000cba/c", arr_flat, struct_z);
    end
    checks++;
    if (short !== 1'b1 || ovf !== 1'b0 || frame_len !== 10'd3 || frame_vld !== 1'b1) begin
      errors++;
      $display("FAIL short_flags: short=%b ovf=%b len=%0d vld=%b required 1/0/3/1", short, ovf, frame_len, frame_vld);
    end
    release_frame();
  endtask

  task automatic test_overflow();
    logic [AW-1:0] exp_arr;
    exp_arr = '0;
    for (int k = 1; k <= 12; k++) begin
      if (k <= 9) exp_arr[(k-1)*4 +: 4] = 4'(k);
      send_beat(4'(k), k == 12);
      if (k == 9) begin
        checks++;
        if (frame_vld !== 1'b0 || ovf !== 1'b1 || s_inf.ready !== 1'b1 || state_dbg !== DRAIN) begin
          errors++;
          $display("FAIL ovf_drain: vld=%b ovf=%b ready=%b st=%0d required 0/1/1/DRAIN", frame_vld, ovf, s_inf.ready, state_dbg);
        end
      end
    end
    s_inf.valid = 1'b0;
    checks++;
    if (arr_flat !== exp_arr || struct_z.op !== 4'd9) begin
      errors++; $display("FAIL ovf_data: arr=%h z=%h required %h/9", arr_flat, struct_z, exp_arr);
    end
    checks++;
    if (ovf !== 1'b1 || short !== 1'b0 || frame_len !== 10'd12 || frame_vld !== 1'b1) begin
      errors++;
      $display("FAIL ovf_flags: ovf=%b short=%b len=%0d vld=%b required 1/0/12/1", ovf, short, frame_len, frame_vld);
    end
    release_frame();
  endtask

  task automatic test_back_to_back();
    int prev;
    frame_rdy = 1'b1;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      send_beat(4'(i + 5), 1'b1);
      checks++;
      if (frame_vld !== 1'b1 || arr_flat !== AW'(i + 5) || short !== 1'b1 || frame_len !== 10'd1 || s_inf.ready !== 1'b0) begin
        errors++;
        $display("FAIL b2b_frame%0d: vld=%b arr=%h short=%b len=%0d ready=%b required 1/%h/1/1/0",
                 i, frame_vld, arr_flat, short, frame_len, s_inf.ready, AW'(i + 5));
      end
      if (i > 0) begin
        checks++;
        if (last_acc_cyc - prev !== 2) begin
          errors++; $display("FAIL b2b_spacing%0d: got %0d cycles required 2", i, last_acc_cyc - prev);
        end
      end
      prev = last_acc_cyc;
    end
    idle(1);
    frame_rdy = 1'b0;
    checks++;
    if (frame_vld !== 1'b0 || arr_flat !== '0) begin
      errors++; $display("FAIL b2b_end: vld=%b arr=%h required 0/0", frame_vld, arr_flat);
    end
  endtask

  task automatic test_reset_mid();
    logic [AW-1:0] exp_arr;
    for (int k = 0; k < 4; k++) send_beat(4'(7 - k), 1'b0);
    s_inf.valid = 1'b0;
    rst = 1'b1;
    @(posedge clock);
    #1;
    rst = 1'b0;
    checks++;
    if (arr_flat !== '0 || struct_z !== '0 || frame_len !== '0 || frame_vld !== 1'b0 ||
        ovf !== 1'b0 || short !== 1'b0 || s_inf.ready !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_clear: arr=%h z=%h len=%0d vld=%b ovf=%b short=%b ready=%b required zeros, ready 1",
               arr_flat, struct_z, frame_len, frame_vld, ovf, short, s_inf.ready);
    end
    exp_arr = '0;
    for (int k = 1; k <= 9; k++) begin
      exp_arr[(k-1)*4 +: 4] = 4'(10 - k);
      send_beat(4'(10 - k), k == 9);
    end
    s_inf.valid = 1'b0;
    checks++;
    if (arr_flat !== exp_arr || frame_len !== 10'd9 || short !== 1'b0 || frame_vld !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_frame: arr=%h len=%0d short=%b vld=%b required %h/9/0/1", arr_flat, frame_len, short, frame_vld, exp_arr);
    end
    release_frame();
  endtask

  task automatic rnd_driver();
    logic [3:0]    beats[12];
    logic [AW-1:0] arr;
    int            len;
    for (int f = 0; f < N_RND; f++) begin
      len = $urandom_range(1, 12);
      arr = '0;
      for (int b = 0; b < len; b++) begin
        beats[b] = 4'($urandom_range(0, 15));
        if (b < DEPTH) arr[b*4 +: 4] = beats[b];
      end
      exp_q.push_back({arr, LEN_W'(len), len > DEPTH, len < DEPTH});
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        send_beat(beats[b], b == len - 1);
      end
      s_inf.valid = 1'b0;
    end
  endtask

  // scoreboard
  task automatic rnd_consumer();
    int            got;
    int            budget;
    int            n;
    logic          rdy;
    logic [EW-1:0] e;
    logic [AW-1:0] e_arr;
    got = 0;
    budget = 0;
    while (got < N_RND && budget < 30000) begin
      @(posedge clock);
      #1;
      budget++;
      if (frame_vld === 1'b1) begin
        checks++;
        if (s_inf.ready !== 1'b0) begin errors++; $display("FAIL rnd_ready_in_hold: ready=%b required 0", s_inf.ready); end
      end
      rdy = ($urandom_range(0, 3) != 0);
      if (frame_vld === 1'b1 && rdy) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rnd_unexpected_frame: arr=%h required no frame", arr_flat);
        end else begin
          e     = exp_q.pop_front();
          e_arr = e[EW-1 -: AW];
          n     = (int'(e[LEN_W+1:2]) > DEPTH) ? DEPTH : int'(e[LEN_W+1:2]);
          if (arr_flat !== e_arr || frame_len !== e[LEN_W+1:2] || ovf !== e[1] || short !== e[0] ||
              struct_z.op !== e_arr[(n-1)*4 +: 4]) begin
            errors++;
            $display("FAIL rnd_frame%0d: arr=%h len=%0d ovf=%b short=%b z=%h required %h/%0d/%b/%b/%h",
                     got, arr_flat, frame_len, ovf, short, struct_z, e_arr, e[LEN_W+1:2], e[1], e[0], e_arr[(n-1)*4 +: 4]);
          end
        end
        got++;
      end
      frame_rdy = rdy;
    end
    frame_rdy = 1'b0;
    checks++;
    if (got != N_RND) begin errors++; $display("FAIL rnd_timeout: frames=%0d required %0d", got, N_RND); end
  endtask

  task automatic test_random();
    fork
      rnd_driver();
      rnd_consumer();
    join
    idle(2);
  endtask

  // final report
  initial begin
    test_reset();
    test_full_frame();
    test_short();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
